// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave sequencing controller.
package i2c_slave_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned BITCNT_W      = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises raw SCL/SDA and produces SCL edge and START/STOP pulses.
// Ports: pclk/preset; scl_in/sda_in raw pads; sda_sync synchronised SDA;
//        scl_rise_c/scl_fall_c/start_c/stop_c single-pclk event pulses.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic preset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_sync,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Synchronisers and one-pclk-delayed copies; flushed to the idle bus level.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_sync;
    end
  end

  assign scl_s    = scl_pipe[SYNC_STAGES-1];
  assign sda_sync = sda_pipe[SYNC_STAGES-1];

  // SDA transitions are only bus conditions when SCL is high on both samples.
  assign scl_rise_c = scl_s & ~scl_d;
  assign scl_fall_c = ~scl_s & scl_d;
  assign start_c    = scl_s & scl_d & sda_d & ~sda_sync;
  assign stop_c     = scl_s & scl_d & ~sda_d & sda_sync;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Sequencing controller for the I2C slave shift-register datapath.
// Ports: pclk/preset/enable; scl_in/sda_in raw pads; comp_match, read,
//        dr_data, sda_out_sr from the datapath; shift_en/shift_load_en,
//        ack_cycle/dack_cycle and sda_sync to the datapath; sda_oe pad
//        pull-low enable; rx_data/rx_valid, tx_req, nack_received, busy.
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       enable,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       comp_match,
  input  logic       read,
  input  logic [7:0] dr_data,
  input  logic       sda_out_sr,
  output logic       shift_en,
  output logic       shift_load_en,
  output logic       ack_cycle,
  output logic       dack_cycle,
  output logic       sda_sync,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       nack_received,
  output logic       busy
);

  i2c_state_e          state, state_nx;
  logic [BITCNT_W-1:0] bitcnt, bitcnt_nx;
  logic                scl_rise_c, scl_fall_c, start_c, stop_c;
  logic                fall_d1, fall_d2;
  logic                ack_bit;
  logic                byte_done_c;
  logic                shift_en_nx, load_nx, rx_valid_nx, tx_req_nx, nack_nx;
  logic                sda_oe_nx, busy_nx;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_bus_monitor (
    .pclk       (pclk),
    .preset     (preset),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_sync   (sda_sync),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  assign byte_done_c = (bitcnt == BITCNT_W'(BITS_PER_BYTE));

  // State register, bit counter, SCL-fall delay line and master ACK sample.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      bitcnt  <= '0;
      fall_d1 <= 1'b0;
      fall_d2 <= 1'b0;
      ack_bit <= I2C_NACK;
    end else begin
      state   <= state_nx;
      bitcnt  <= bitcnt_nx;
      fall_d1 <= scl_fall_c;
      fall_d2 <= fall_d1;
      if (state == TX_ACK && scl_rise_c) ack_bit <= sda_sync;
    end
  end

  // Next-state: bus conditions and enable override every state.
  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    if (!enable || stop_c) begin
      state_nx  = IDLE;
      bitcnt_nx = '0;
    end else if (start_c) begin
      state_nx  = ADDR;
      bitcnt_nx = '0;
    end else begin
      case (state)
        ADDR, RX, TX: begin
          if (scl_rise_c) begin
            bitcnt_nx = bitcnt + BITCNT_W'(1);
          end else if (scl_fall_c && byte_done_c) begin
            case (state)
              ADDR:    state_nx = comp_match ? ADDR_ACK : WAIT_STOP;
              RX:      state_nx = RX_ACK;
              default: state_nx = TX_ACK;
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c) begin
            state_nx  = read ? TX : RX;
            bitcnt_nx = '0;
          end
        end
        RX_ACK: begin
          if (scl_fall_c) begin
            state_nx  = RX;
            bitcnt_nx = '0;
          end
        end
        TX_ACK: begin
          if (scl_fall_c) begin
            state_nx  = (ack_bit == I2C_ACK) ? TX : WAIT_STOP;
            bitcnt_nx = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: next values of the registered strobes, busy and SDA drive.
  always_comb begin
    shift_en_nx = 1'b0;
    load_nx     = 1'b0;
    rx_valid_nx = 1'b0;
    tx_req_nx   = 1'b0;
    nack_nx     = 1'b0;
    busy_nx     = busy;
    sda_oe_nx   = sda_oe;
    if (!enable || stop_c) begin
      busy_nx   = 1'b0;
      sda_oe_nx = 1'b0;
    end else if (start_c) begin
      busy_nx   = 1'b1;
      sda_oe_nx = 1'b0;
    end else begin
      case (state)
        ADDR, TX: shift_en_nx = scl_rise_c;
        RX: begin
          shift_en_nx = scl_rise_c;
          rx_valid_nx = scl_fall_c && byte_done_c;
        end
        ADDR_ACK: begin
          load_nx   = scl_fall_c && read;
          tx_req_nx = scl_fall_c && read;
        end
        TX_ACK: begin
          load_nx   = scl_fall_c && (ack_bit == I2C_ACK);
          tx_req_nx = scl_fall_c && (ack_bit == I2C_ACK);
          nack_nx   = scl_fall_c && (ack_bit == I2C_NACK);
        end
        default: ;
      endcase
      // Two pclk after the fall pulse the datapath has absorbed the load and
      // the ack-phase change, so sda_out_sr is current while SCL is still low.
      if (fall_d2) begin
        sda_oe_nx = (state == ADDR_ACK || state == RX_ACK || state == TX) ?
                    ~sda_out_sr : 1'b0;
      end
    end
  end

  // Registered outputs; ack phases are aligned with the state they mark.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      shift_en      <= 1'b0;
      shift_load_en <= 1'b0;
      ack_cycle     <= 1'b0;
      dack_cycle    <= 1'b0;
      sda_oe        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      tx_req        <= 1'b0;
      nack_received <= 1'b0;
      busy          <= 1'b0;
    end else begin
      shift_en      <= shift_en_nx;
      shift_load_en <= load_nx;
      ack_cycle     <= (state_nx == ADDR_ACK) || (state_nx == TX_ACK);
      dack_cycle    <= (state_nx == RX_ACK) || (state_nx == TX_ACK);
      sda_oe        <= sda_oe_nx;
      rx_valid      <= rx_valid_nx;
      tx_req        <= tx_req_nx;
      nack_received <= nack_nx;
      busy          <= busy_nx;
      if (rx_valid_nx) rx_data <= dr_data;
    end
  end

endmodule
